// File: rtl/p5_pkg.sv
// Shared P5 pipeline definitions: forward-select codes, Tuse/Tnew constants
// and the per-stage writer record used by the GRF hazard controller.
package p5_pkg;

  localparam int unsigned GRF_AW = 5;
  localparam int unsigned GRF_TW = 2;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_t;

  localparam logic [GRF_TW-1:0] TUSE_NONE = 2'd3;
  localparam logic [GRF_TW-1:0] T_ALU     = 2'd1;
  localparam logic [GRF_TW-1:0] T_LOAD    = 2'd2;
  localparam logic [GRF_TW-1:0] T_LINK    = 2'd0;

  typedef struct packed {
    logic              v;
    logic [GRF_AW-1:0] dst;
    logic [GRF_TW-1:0] tn;
  } stage_t;

  // Tnew counts down once per stage and sticks at zero once the result exists.
  function automatic logic [GRF_TW-1:0] tn_dec(input logic [GRF_TW-1:0] tn);
    return (tn == '0) ? '0 : tn - 1'b1;
  endfunction

endpackage

// File: rtl/grf_fwd_pick.sv
// Youngest-match selector: finds the youngest allowed stage writing src and
// reports either its forward code (result ready) or its outstanding Tnew.
module grf_fwd_pick
  import p5_pkg::*;
(
  input  logic [GRF_AW-1:0] src,
  input  stage_t            e,
  input  stage_t            m,
  input  stage_t            w,
  input  logic [2:0]        mask,
  output fwd_t              sel,
  output logic [GRF_TW-1:0] pending_tn
);

  // mask[2]=E, mask[1]=M, mask[0]=W; the first hit shadows all older stages.
  always_comb begin
    sel        = FWD_GRF;
    pending_tn = '0;
    if (src != '0) begin
      if (mask[2] && e.v && e.dst == src) begin
        if (e.tn == '0) sel = FWD_E;
        else            pending_tn = e.tn;
      end else if (mask[1] && m.v && m.dst == src) begin
        if (m.tn == '0) sel = FWD_M;
        else            pending_tn = m.tn;
      end else if (mask[0] && w.v && w.dst == src) begin
        if (w.tn == '0) sel = FWD_W;
        else            pending_tn = w.tn;
      end
    end
  end

endmodule

// File: rtl/grf_hazard_ctrl.sv
// GRF hazard/bypass controller for the P5 pipeline: shadow E/M/W writer
// records, D stall, forward selects and GRF write port. Optional: HAZARD_STALL_CNT_EN.
module grf_hazard_ctrl
  import p5_pkg::*;
#(
  parameter int unsigned REG_AW = GRF_AW,
  parameter int unsigned T_W    = GRF_TW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_tuse_rs,
  input  logic [T_W-1:0]    d_tuse_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [T_W-1:0]    d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [REG_AW-1:0] grf_a3,
  output logic              grf_we
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [2:0] MASK_D = 3'b111;
  localparam logic [2:0] MASK_E = 3'b011;

  stage_t            e_q, m_q, w_q;
  logic [REG_AW-1:0] rs_e, rt_e;

  fwd_t              sel_drs, sel_drt, sel_ers, sel_ert;
  logic [T_W-1:0]    pend_drs, pend_drt;
  logic [T_W-1:0]    pend_ers_unused, pend_ert_unused;

  grf_fwd_pick u_pick_drs (
    .src(d_rs), .e(e_q), .m(m_q), .w(w_q), .mask(MASK_D),
    .sel(sel_drs), .pending_tn(pend_drs)
  );
  grf_fwd_pick u_pick_drt (
    .src(d_rt), .e(e_q), .m(m_q), .w(w_q), .mask(MASK_D),
    .sel(sel_drt), .pending_tn(pend_drt)
  );
  grf_fwd_pick u_pick_ers (
    .src(rs_e), .e(e_q), .m(m_q), .w(w_q), .mask(MASK_E),
    .sel(sel_ers), .pending_tn(pend_ers_unused)
  );
  grf_fwd_pick u_pick_ert (
    .src(rt_e), .e(e_q), .m(m_q), .w(w_q), .mask(MASK_E),
    .sel(sel_ert), .pending_tn(pend_ert_unused)
  );

  assign stall = d_valid &&
                 ((d_tuse_rs != TUSE_NONE && pend_drs > d_tuse_rs) ||
                  (d_tuse_rt != TUSE_NONE && pend_drt > d_tuse_rt));

  assign fwd_d_rs = sel_drs;
  assign fwd_d_rt = sel_drt;
  assign fwd_e_rs = sel_ers;
  assign fwd_e_rt = sel_ert;
  assign grf_a3   = w_q.dst;
  assign grf_we   = w_q.v && (w_q.dst != '0);

  // M and W drain regardless of stall so a stalled consumer always makes progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q  <= '0;
      m_q  <= '0;
      w_q  <= '0;
      rs_e <= '0;
      rt_e <= '0;
    end else begin
      m_q <= '{v: e_q.v, dst: e_q.dst, tn: tn_dec(e_q.tn)};
      w_q <= '{v: m_q.v, dst: m_q.dst, tn: tn_dec(m_q.tn)};
      if (stall || !d_valid) begin
        e_q  <= '0;
        rs_e <= '0;
        rt_e <= '0;
      end else begin
        e_q  <= '{v: 1'b1, dst: d_dst, tn: d_tnew};
        rs_e <= d_rs;
        rt_e <= d_rt;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      stall_q <= stall;
      if (stall && !stall_q)
        $display("%0t: stall rs=%0d rt=%0d", $time, d_rs, d_rt);
    end
  end
`endif

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Self-checking bench for grf_hazard_ctrl: directed pipeline scenarios plus
// randomized instruction streams against an age-indexed writer-history model.
module tb_grf_hazard_ctrl;
  import p5_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [4:0] grf_a3;
  logic       grf_we;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  grf_hazard_ctrl #(.REG_AW(5), .T_W(2)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew), .stall(stall),
    .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .grf_a3(grf_a3), .grf_we(grf_we)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: history of what entered E, indexed by age (0=E,1=M,2=W).
  logic       h_v[3];
  logic [4:0] h_dst[3];
  int         h_tnew[3];
  logic [4:0] e_rs, e_rt;

  logic       exp_stall, exp_we;
  logic [1:0] exp_fdrs, exp_fdrt, exp_fers, exp_fert;
  logic [4:0] exp_a3;

  function automatic int tn_at(input int a);
    int t;
    t = h_tnew[a] - a;
    return (t > 0) ? t : 0;
  endfunction

  function automatic void pick(input logic [4:0] r, input int first,
                               output int code, output int pend);
    bit done;
    done = 1'b0;
    code = 0;
    pend = 0;
    if (r != 5'd0) begin
      for (int a = first; a < 3; a++) begin
        if (!done && h_v[a] && h_dst[a] == r) begin
          done = 1'b1;
          if (tn_at(a) == 0) code = a + 1;
          else               pend = tn_at(a);
        end
      end
    end
  endfunction

  function automatic void model_eval();
    int c_rs, p_rs, c_rt, p_rt, c_ers, p_ers, c_ert, p_ert;
    pick(d_rs, 0, c_rs, p_rs);
    pick(d_rt, 0, c_rt, p_rt);
    pick(e_rs, 1, c_ers, p_ers);
    pick(e_rt, 1, c_ert, p_ert);
    exp_stall = d_valid && ((d_tuse_rs != 2'd3 && p_rs > int'(d_tuse_rs)) ||
                            (d_tuse_rt != 2'd3 && p_rt > int'(d_tuse_rt)));
    exp_fdrs = 2'(c_rs);
    exp_fdrt = 2'(c_rt);
    exp_fers = 2'(c_ers);
    exp_fert = 2'(c_ert);
    exp_a3   = h_dst[2];
    exp_we   = h_v[2] && h_dst[2] != 5'd0;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin
      h_v[a] = 1'b0; h_dst[a] = 5'd0; h_tnew[a] = 0;
    end
    e_rs = 5'd0;
    e_rt = 5'd0;
  endtask

  task automatic model_advance();
    model_eval();
    if (reset) begin
      model_clear();
    end else begin
      for (int a = 2; a > 0; a--) begin
        h_v[a] = h_v[a-1]; h_dst[a] = h_dst[a-1]; h_tnew[a] = h_tnew[a-1];
      end
      if (exp_stall || !d_valid) begin
        h_v[0] = 1'b0; h_dst[0] = 5'd0; h_tnew[0] = 0; e_rs = 5'd0; e_rt = 5'd0;
      end else begin
        h_v[0] = 1'b1; h_dst[0] = d_dst; h_tnew[0] = int'(d_tnew); e_rs = d_rs; e_rt = d_rt;
      end
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] urs, input logic [1:0] urt,
                       input logic [4:0] dst, input logic [1:0] tnew);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_dst = dst; d_tnew = tnew;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, T_LINK);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, grf_a3, grf_we} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, grf_a3, grf_we});
    end
    drive(1'b1, 5'd5, 5'd7, 2'd0, 2'd0, 5'd9, T_ALU);
    checks++;
    if ({stall, fwd_d_rs, fwd_d_rt} !== 5'b0) begin
      errors++;
      $display("FAIL reset_dvalid got=%b exp=0", {stall, fwd_d_rs, fwd_d_rt});
    end
    idle();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd29, 5'd8, 2'd1, TUSE_NONE, 5'd8, T_LOAD);
    tick();
    drive(1'b1, 5'd8, 5'd8, 2'd1, 2'd1, 5'd9, T_ALU);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", stall); end
    tick();
    idle();
    checks++;
    if (fwd_e_rs !== FWD_W) begin errors++; $display("FAIL lu_fwd_e_rs got=%0d exp=3", fwd_e_rs); end
    checks++;
    if (fwd_e_rt !== FWD_W) begin errors++; $display("FAIL lu_fwd_e_rt got=%0d exp=3", fwd_e_rt); end
    checks++;
    if (grf_we !== 1'b1) begin errors++; $display("FAIL lu_grf_we got=%b exp=1", grf_we); end
    checks++;
    if (grf_a3 !== 5'd8) begin errors++; $display("FAIL lu_grf_a3 got=%0d exp=8", grf_a3); end
    tick();
  endtask

  task automatic test_alu_b2b();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd3, T_ALU);
    tick();
    drive(1'b1, 5'd3, 5'd4, 2'd0, 2'd0, 5'd0, T_LINK);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL alu_stall got=%b exp=1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== FWD_M) begin
      errors++;
      $display("FAIL alu_fwd_m got=stall%b/fwd%0d exp=stall0/fwd2", stall, fwd_d_rs);
    end
    idle();
    tick();
  endtask

  task automatic test_shadow();
    do_reset();
    drive(1'b1, 5'd6, 5'd5, 2'd1, TUSE_NONE, 5'd5, T_ALU);
    tick();
    drive(1'b1, 5'd0, 5'd5, TUSE_NONE, TUSE_NONE, 5'd5, T_LINK);
    tick();
    drive(1'b1, 5'd5, 5'd2, 2'd1, 2'd1, 5'd10, T_ALU);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL shadow_stall got=%b exp=0", stall); end
    checks++;
    if (fwd_d_rs !== FWD_E) begin errors++; $display("FAIL shadow_fwd got=%0d exp=1", fwd_d_rs); end
    idle();
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1'b1, 5'd29, 5'd0, 2'd1, TUSE_NONE, 5'd0, T_LOAD);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'd1, 2'd1, 5'd11, T_ALU);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b exp=0", stall); end
    checks++;
    if ({fwd_d_rs, fwd_d_rt} !== 4'b0) begin
      errors++; $display("FAIL zero_fwd got=%b exp=0", {fwd_d_rs, fwd_d_rt});
    end
    tick();
    idle();
    tick();
    checks++;
    if (grf_we !== 1'b0) begin errors++; $display("FAIL zero_grf_we got=%b exp=0", grf_we); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 5'd29, 5'd8, 2'd1, TUSE_NONE, 5'd8, T_LOAD);
    tick();
    drive(1'b1, 5'd8, 5'd8, 2'd1, 2'd1, 5'd9, T_ALU);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall_pre got=%b exp=1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall got=%b exp=0", stall); end
    checks++;
    if (grf_we !== 1'b0) begin errors++; $display("FAIL rms_grf_we got=%b exp=0", grf_we); end
    checks++;
    if ({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt} !== 8'b0) begin
      errors++;
      $display("FAIL rms_fwd got=%b exp=0", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt});
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      model_eval();
      checks++;
      if (stall !== exp_stall) begin errors++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall, exp_stall); end
      checks++;
      if (fwd_d_rs !== exp_fdrs) begin errors++; $display("FAIL rand_fwd_d_rs n=%0d got=%0d exp=%0d", n, fwd_d_rs, exp_fdrs); end
      checks++;
      if (fwd_d_rt !== exp_fdrt) begin errors++; $display("FAIL rand_fwd_d_rt n=%0d got=%0d exp=%0d", n, fwd_d_rt, exp_fdrt); end
      checks++;
      if (fwd_e_rs !== exp_fers) begin errors++; $display("FAIL rand_fwd_e_rs n=%0d got=%0d exp=%0d", n, fwd_e_rs, exp_fers); end
      checks++;
      if (fwd_e_rt !== exp_fert) begin errors++; $display("FAIL rand_fwd_e_rt n=%0d got=%0d exp=%0d", n, fwd_e_rt, exp_fert); end
      checks++;
      if (grf_a3 !== exp_a3) begin errors++; $display("FAIL rand_grf_a3 n=%0d got=%0d exp=%0d", n, grf_a3, exp_a3); end
      checks++;
      if (grf_we !== exp_we) begin errors++; $display("FAIL rand_grf_we n=%0d got=%b exp=%b", n, grf_we, exp_we); end
      tick();
    end
    reset = 1'b0;
  endtask

`ifdef HAZARD_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd29, 5'd8, 2'd1, TUSE_NONE, 5'd8, T_LOAD);
      tick();
      drive(1'b1, 5'd8, 5'd8, 2'd1, 2'd1, 5'd9, T_ALU);
      tick();
      tick();
      idle();
      tick();
      tick();
    end
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    do_reset();
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_cnt_reset got=%0d exp=0", stall_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    model_clear();
    idle();
    test_reset();
    test_load_use();
    test_alu_b2b();
    test_shadow();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
`ifdef HAZARD_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grf_hazard_ctrl.md
Name: grf_hazard_ctrl

Overview:
Hazard and bypass controller for the general register file in the 5-stage P5 pipeline (F/D/E/M/W).
- Keeps a shadow pipeline of in-flight register writers: destination, Tnew and valid for E, M and W.
- Compares D- and E-stage source registers against that shadow pipeline to produce the D stall, the forward-mux selects and the GRF write port controls (a3, we).

Parameters:
REG_AW, 5, register address width (32 GPRs, $0 hard-wired to zero)
T_W, 2, width of Tnew/Tuse fields

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
d_valid  in  1  D stage holds a real instruction
d_rs  in  REG_AW  D-stage rs
d_rt  in  REG_AW  D-stage rt
d_tuse_rs  in  T_W  cycles from D until rs consumed; 3 = not used
d_tuse_rt  in  T_W  as above for rt
d_dst  in  REG_AW  D-stage destination register (0 = no write)
d_tnew  in  T_W  cycles after E entry until result exists (ALU=1, load=2, link/lui=0)
stall  out  1  freeze PC and IF/ID, bubble into ID/EX
fwd_d_rs  out  2  D-stage rs source: 0 GRF, 1 E, 2 M, 3 W
fwd_d_rt  out  2  as above for rt
fwd_e_rs  out  2  E-stage rs source: 0 pipeline reg, 2 M, 3 W
fwd_e_rt  out  2  as above for rt
grf_a3  out  REG_AW  GRF write address (W-stage dst)
grf_we  out  1  GRF write enable

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- State per stage X in {E, M, W}: vX, dstX, tnX. E also holds rsE/rtE.
- Reset: all vX=0, dst=0, tn=0, rsE/rtE=0, so every output reads 0.
- Advance (every posedge, not in reset):
  - M<=E and W<=M always. Tn saturating decrement: tnM<=max(tnE-1,0), tnW<=max(tnM-1,0).
  - E: if stall or !d_valid, E<=bubble (vE=0, dst=0). Otherwise E<={1, d_dst, d_tnew, d_rs, d_rt}.
- match(X,r): vX && dstX==r && r!=0.
- stall is combinational: d_valid && exists r in {rs,rt} with tuse!=3 and the youngest matching stage has tn > tuse.
  - Youngest-match priority is E > M > W. An older match is shadowed by a younger one.
- fwd_d_r:
  - Youngest matching stage with tn==0: 1 for E, 2 for M, 3 for W.
  - If the youngest match has tn>0, or there is no match, the value is 0.
- fwd_e_r:
  - Youngest match of rsE/rtE among M and W with tn==0: 2 for M, 3 for W. Otherwise 0.
  - A pending non-zero tn here cannot occur when the stall rule is satisfied.
- grf_a3=dstW, grf_we=vW && dstW!=0. Writes to $0 are therefore suppressed here as well.
- Register $0 never matches, never stalls and never forwards.
- During stall, M/W keep draining, so a stall resolves within at most 2 cycles.
- Reset asserted mid-stall clears all state; stall drops in the same cycle reset is sampled.
- Outputs are a pure function of the registered state and the D inputs. No combinational path exists from grf_* to stall.

Optional Feature:
HAZARD_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0].
  - Increments on every cycle with stall=1 and reset=0; wraps at 2^32-1 to 0; cleared by reset.
  - Adds a $display of time and stalled rs/rt on each stall rising edge.
- Undefined: the port and counter are absent; the remaining behaviour is identical.

Decomposition:
- Shared package p5_pkg holds:
  - FWD_GRF=0, FWD_E=1, FWD_M=2, FWD_W=3.
  - TUSE_NONE=3.
  - Tnew constants (T_ALU=1, T_LOAD=2, T_LINK=0).
  - Stage-record typedef {v, dst, tn}.
- One natural sub-module, grf_fwd_pick: combinational youngest-match selector taking (reg, E/M/W records, allowed-stage mask) and returning (sel, pending_tn). Instantiate it four times (D rs/rt, E rs/rt).

Test Plan:
- Load-use: lw $8 (dst=8, tnew=2) then addu $9,$8,$8 (tuse=1): stall=1 for 1 cycle, then fwd_e_rs=fwd_e_rt=3 (W) next cycle; grf_we=1, grf_a3=8 two cycles later.
- ALU back-to-back: addu $3 (tnew=1) then beq $3 (tuse_rs=0): stall=1 one cycle; then fwd_d_rs=2 (M).
- Shadowing: ori $5 then lui $5 (tnew=0) then addu using $5 at D: fwd_d_rs=1 (E, lui), not M.
- $0: lw $0 then addu using $0: stall=0, fwd=0, grf_we=0 when the lw reaches W.
- Reset mid-stall: assert reset on the stall cycle of the load-use case: the next cycle stall=0, grf_we=0 and all fwd=0.
- HAZARD_STALL_CNT_EN defined: run 3 load-use pairs: stall_cnt=3; reset: stall_cnt=0.
